// File: rtl/coin_pkg.sv
// Shared coin encoding for the vending DataPath: codes match the adder select,
// plus the code-to-value helper and the credit width.
package coin_pkg;

    localparam int CREDIT_W = 7;

    typedef logic [1:0] coin_code_t;

    localparam coin_code_t COIN_1  = 2'b00;
    localparam coin_code_t COIN_2  = 2'b01;
    localparam coin_code_t COIN_10 = 2'b10;
    localparam coin_code_t COIN_20 = 2'b11;

    function automatic logic [4:0] coin_value(input coin_code_t code);
        case (code)
            COIN_1:  coin_value = 5'd1;
            COIN_2:  coin_value = 5'd2;
            COIN_10: coin_value = 5'd10;
            default: coin_value = 5'd20;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchroniser, stable-count debounce and a one-cycle
// pulse on each debounced rising edge.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Level has differed for DEBOUNCE_CYCLES samples in a row.
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_intake.sv
// Coin intake: debounce four slots, arbitrate, enforce the credit ceiling and
// queue accepted coins. Optional counters under COIN_INTAKE_STATS_EN.
module coin_intake
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_CREDIT      = 40
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [3:0]          COIN_IN,
    input  logic [CREDIT_W-1:0] A,
    input  logic                COIN_TAKEN,
    output logic                COIN_VALID,
    output logic [1:0]          SEL_ADD_IN,
    output logic [CREDIT_W-1:0] PENDING,
    output logic                FULL,
    output logic                REJECT,
    output logic [1:0]          REJECT_CODE
`ifdef COIN_INTAKE_STATS_EN
    ,
    output logic [7:0]          ACCEPT_CNT,
    output logic [7:0]          REJECT_CNT
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]          rise;
    logic [3:0]          pend;
    logic [1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                svc;
    coin_code_t          code;
    logic [4:0]          val;
    logic [4:0]          head_val;
    logic [7:0]          total;
    logic                over;
    logic                full_now;
    logic                push;
    logic                rej;
    logic                pop;
    logic [3:0]          clr;
    logic [CNT_W-1:0]    remain;
    logic [CNT_W-1:0]    count_next;
    logic [PTR_W-1:0]    rd_next;
    coin_code_t          sel_next;
    logic [CREDIT_W-1:0] pending_next;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (COIN_IN[i]),
            .rise (rise[i])
        );
    end

    always_comb begin
        svc = |pend;
        // Slot index doubles as the coin code; highest slot wins.
        if (pend[3])      code = COIN_20;
        else if (pend[2]) code = COIN_10;
        else if (pend[1]) code = COIN_2;
        else              code = COIN_1;

        val      = coin_value(code);
        head_val = coin_value(SEL_ADD_IN);
        total    = {1'b0, A} + {1'b0, PENDING} + {3'b000, val};
        over     = total > 8'(MAX_CREDIT);
        full_now = count == CNT_W'(FIFO_DEPTH);

        push = svc && EN && !over && !full_now;
        rej  = svc && (!EN || over);
        clr  = (push || rej) ? (4'b0001 << code) : 4'b0000;
        pop  = COIN_TAKEN && COIN_VALID;

        remain     = count - CNT_W'(pop);
        count_next = remain + CNT_W'(push);
        rd_next    = rd_ptr + PTR_W'(pop);

        if (remain == '0) sel_next = push ? code : COIN_1;
        else              sel_next = mem[rd_next];

        pending_next = PENDING;
        if (push) pending_next = pending_next + {2'b00, val};
        if (pop)  pending_next = pending_next - {2'b00, head_val};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            COIN_VALID  <= 1'b0;
            SEL_ADD_IN  <= COIN_1;
            PENDING     <= '0;
            FULL        <= 1'b0;
            REJECT      <= 1'b0;
            REJECT_CODE <= COIN_1;
        end else begin
            pend        <= (pend & ~clr) | rise;
            wr_ptr      <= wr_ptr + PTR_W'(push);
            rd_ptr      <= rd_next;
            count       <= count_next;
            COIN_VALID  <= count_next != '0;
            SEL_ADD_IN  <= sel_next;
            PENDING     <= pending_next;
            FULL        <= count_next == CNT_W'(FIFO_DEPTH);
            REJECT      <= rej;
            REJECT_CODE <= rej ? code : COIN_1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= code;
    end

`ifdef COIN_INTAKE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ACCEPT_CNT <= '0;
            REJECT_CNT <= '0;
        end else begin
            if (push && ACCEPT_CNT != 8'hFF) ACCEPT_CNT <= ACCEPT_CNT + 8'd1;
            if (rej && REJECT_CNT != 8'hFF)  REJECT_CNT <= REJECT_CNT + 8'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake: expected head coins and reject codes are
// queued as stimulus is issued and a negedge monitor consumes them.
module tb_coin_intake;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] COIN_IN;
    logic [6:0] A;
    logic       COIN_TAKEN;
    logic       COIN_VALID;
    logic [1:0] SEL_ADD_IN;
    logic [6:0] PENDING;
    logic       FULL;
    logic       REJECT;
    logic [1:0] REJECT_CODE;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_head[$];
    logic [1:0] exp_rej[$];

    coin_intake dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .COIN_IN     (COIN_IN),
        .A           (A),
        .COIN_TAKEN  (COIN_TAKEN),
        .COIN_VALID  (COIN_VALID),
        .SEL_ADD_IN  (SEL_ADD_IN),
        .PENDING     (PENDING),
        .FULL        (FULL),
        .REJECT      (REJECT),
        .REJECT_CODE (REJECT_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every reject pulse and every pop is matched against the queues.
    always @(negedge CLK) begin
        if (!RST) begin
            if (REJECT) begin
                if (exp_rej.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reject_unexpected: got code %0d, expected no reject", REJECT_CODE);
                end else begin
                    check("sb_reject_code", int'(REJECT_CODE), int'(exp_rej.pop_front()));
                end
            end
            if (COIN_TAKEN && COIN_VALID) begin
                if (exp_head.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got head %0d, expected empty", SEL_ADD_IN);
                end else begin
                    check("sb_head_code", int'(SEL_ADD_IN), int'(exp_head.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b0; A = 7'd0; COIN_IN = 4'b0000; COIN_TAKEN = 1'b0;
        tick(3);
        check("rst_valid",   int'(COIN_VALID),  0);
        check("rst_sel",     int'(SEL_ADD_IN),  0);
        check("rst_pending", int'(PENDING),     0);
        check("rst_full",    int'(FULL),        0);
        check("rst_reject",  int'(REJECT),      0);
        check("rst_rcode",   int'(REJECT_CODE), 0);
        RST = 1'b0; EN = 1'b1;

        // Single 10-unit coin: head offered in cycle 8.
        exp_head.push_back(2'b10);
        COIN_IN = 4'b0100;
        tick(7);
        check("t1_valid_c7",   int'(COIN_VALID), 0);
        tick(1);
        check("t1_valid_c8",   int'(COIN_VALID), 1);
        check("t1_sel",        int'(SEL_ADD_IN), 2);
        check("t1_pending",    int'(PENDING),    10);
        tick(12);
        COIN_IN = 4'b0000;
        tick(10);
        COIN_TAKEN = 1'b1;
        tick(1);
        COIN_TAKEN = 1'b0;
        check("t1_valid_pop",   int'(COIN_VALID), 0);
        check("t1_pending_pop", int'(PENDING),    0);

        // Three-cycle glitch must be filtered.
        COIN_IN = 4'b0001;
        tick(3);
        COIN_IN = 4'b0000;
        tick(15);
        check("t2_valid",   int'(COIN_VALID), 0);
        check("t2_pending", int'(PENDING),    0);

        // Simultaneous 20 and 1: 20 first, 1 a cycle later.
        exp_head.push_back(2'b11);
        exp_head.push_back(2'b00);
        COIN_IN = 4'b1001;
        tick(8);
        check("t3_valid",     int'(COIN_VALID), 1);
        check("t3_sel",       int'(SEL_ADD_IN), 3);
        check("t3_pending20", int'(PENDING),    20);
        tick(1);
        check("t3_pending21", int'(PENDING),    21);
        check("t3_sel_keep",  int'(SEL_ADD_IN), 3);
        check("t3_full",      int'(FULL),       0);
        tick(4);
        COIN_IN = 4'b0000;
        tick(10);
        COIN_TAKEN = 1'b1;
        tick(2);
        COIN_TAKEN = 1'b0;
        check("t3_pending_end", int'(PENDING),    0);
        check("t3_valid_end",   int'(COIN_VALID), 0);

        // Credit ceiling: 30+20 rejected, 30+10 exactly at the ceiling accepted.
        A = 7'd30;
        exp_rej.push_back(2'b11);
        COIN_IN = 4'b1000;
        tick(8);
        check("t4_reject",      int'(REJECT),      1);
        check("t4_rcode",       int'(REJECT_CODE), 3);
        tick(1);
        check("t4_reject_off",  int'(REJECT),      0);
        check("t4_pending",     int'(PENDING),     0);
        check("t4_valid",       int'(COIN_VALID),  0);
        COIN_IN = 4'b0000;
        tick(10);
        exp_head.push_back(2'b10);
        COIN_IN = 4'b0100;
        tick(8);
        check("t4_acc_valid",   int'(COIN_VALID),  1);
        check("t4_acc_pending", int'(PENDING),     10);
        check("t4_acc_noreject", int'(REJECT),     0);
        tick(2);
        COIN_IN = 4'b0000;
        tick(10);
        COIN_TAKEN = 1'b1;
        tick(1);
        COIN_TAKEN = 1'b0;
        A = 7'd0;
        check("t4_pending_end", int'(PENDING), 0);

        // Full FIFO: fifth coin waits, then enters the cycle after a pop.
        for (int k = 0; k < 5; k++) begin
            exp_head.push_back(2'b00);
            COIN_IN = 4'b0001;
            tick(6);
            COIN_IN = 4'b0000;
            tick(8);
        end
        check("t5_full",         int'(FULL),       1);
        check("t5_pending4",     int'(PENDING),    4);
        check("t5_valid",        int'(COIN_VALID), 1);
        COIN_TAKEN = 1'b1;
        tick(1);
        COIN_TAKEN = 1'b0;
        check("t5_full_pop",     int'(FULL),       0);
        check("t5_pending_pop",  int'(PENDING),    3);
        tick(1);
        check("t5_full_refill",  int'(FULL),       1);
        check("t5_pending_refill", int'(PENDING),  4);
        COIN_TAKEN = 1'b1;
        tick(4);
        COIN_TAKEN = 1'b0;
        check("t5_pending_end",  int'(PENDING),    0);
        check("t5_valid_end",    int'(COIN_VALID), 0);
        check("t5_full_end",     int'(FULL),       0);

        // EN=0 rejects; reset discards queued coins silently.
        EN = 1'b0;
        exp_rej.push_back(2'b01);
        COIN_IN = 4'b0010;
        tick(8);
        check("t6_reject",     int'(REJECT),      1);
        check("t6_rcode",      int'(REJECT_CODE), 1);
        tick(1);
        check("t6_reject_off", int'(REJECT),      0);
        check("t6_valid",      int'(COIN_VALID),  0);
        COIN_IN = 4'b0000;
        tick(10);
        EN = 1'b1;
        COIN_IN = 4'b0011;
        tick(10);
        check("t6_q_valid",    int'(COIN_VALID),  1);
        check("t6_q_pending",  int'(PENDING),     3);
        check("t6_q_sel",      int'(SEL_ADD_IN),  1);
        COIN_IN = 4'b0000;
        tick(10);
        RST = 1'b1;
        tick(1);
        check("t6_rst_valid",   int'(COIN_VALID), 0);
        check("t6_rst_pending", int'(PENDING),    0);
        check("t6_rst_reject",  int'(REJECT),     0);
        check("t6_rst_full",    int'(FULL),       0);
        check("t6_rst_sel",     int'(SEL_ADD_IN), 0);
        RST = 1'b0;
        tick(12);
        check("t6_post_valid",  int'(COIN_VALID), 0);

        check("sb_head_drained",   exp_head.size(), 0);
        check("sb_reject_drained", exp_rej.size(),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
